// File: rtl/afifo_pkg.sv
// rtl/afifo_pkg.sv - shared async FIFO constants and Gray code helpers
package afifo_pkg;

  localparam int DEFAULT_ADDR_W = 3;
  localparam int PTR_W          = DEFAULT_ADDR_W + 1;
  localparam int MAX_W          = 32;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b, input int w);
    logic [MAX_W-1:0] mask;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    return (b ^ (b >> 1)) & mask;
  endfunction

  // Bits at or above w are ignored so any pointer width can share one function.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g, input int w);
    logic [MAX_W-1:0] bin;
    logic             acc;
    bin = '0;
    acc = 1'b0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (i < w) begin
        acc    = acc ^ g[i];
        bin[i] = acc;
      end
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin_dec.sv
// rtl/gray2bin_dec.sv - combinational Gray to binary XOR-prefix decoder
module gray2bin_dec
  import afifo_pkg::*;
#(
  parameter int W = PTR_W
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the parity of all Gray bits at or above it.
  for (genvar i = 0; i < W; i++) begin : g_xor
    assign bin[i] = ^(gray >> i);
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// rtl/wptr_full_ctrl.sv - write-side pointer, full/almost-full, count and overflow
module wptr_full_ctrl
  import afifo_pkg::*;
#(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int AFULL_THRESH = 6
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              winc,
  input  logic [ADDR_W:0]   wq2_rptr,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr,
  output logic              wfull,
  output logic              walmost_full,
  output logic [ADDR_W:0]   wcount,
  output logic              woverflow
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbinnext;
  logic [PW-1:0] wgraynext;
  logic [PW-1:0] rbin;
  logic [PW-1:0] wcount_next;
  logic          wfull_next;
  logic          walmost_full_next;

  gray2bin_dec #(.W(PW)) u_rptr_dec (
    .gray (wq2_rptr),
    .bin  (rbin)
  );

  assign wen       = winc & ~wfull;
  assign waddr     = wbin[ADDR_W-1:0];
  assign wbinnext  = wbin + {{ADDR_W{1'b0}}, wen};
  assign wgraynext = PW'(bin2gray(MAX_W'(wbinnext), PW));

  // Full when the write pointer has lapped the read pointer: top two Gray bits differ.
  assign wfull_next        = (wgraynext == {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]});
  assign wcount_next       = wbinnext - rbin;
  assign walmost_full_next = (wcount_next >= PW'(AFULL_THRESH));

  // wptr comes straight from a register so the crossing sees one-bit steps only.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wcount       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= wfull_next;
      walmost_full <= walmost_full_next;
      wcount       <= wcount_next;
      woverflow    <= woverflow | (winc & wfull);
    end
  end

endmodule
